// File: rtl/instruction_decoder_seq_pkg.sv
// Shared definitions for the registered instruction decoder: default opcode
// width, the fourteen defined operations, default classification masks and
// the decoder state encoding.
package instr_dec_pkg;

    localparam int OPW_DEFAULT = 4;

    // Defined operations; each one maps to one bit of the control word.
    localparam logic [OPW_DEFAULT-1:0] OP_LOAD  = 4'd0;
    localparam logic [OPW_DEFAULT-1:0] OP_STORE = 4'd1;
    localparam logic [OPW_DEFAULT-1:0] OP_ADD   = 4'd2;
    localparam logic [OPW_DEFAULT-1:0] OP_SUB   = 4'd3;
    localparam logic [OPW_DEFAULT-1:0] OP_AND   = 4'd4;
    localparam logic [OPW_DEFAULT-1:0] OP_OR    = 4'd5;
    localparam logic [OPW_DEFAULT-1:0] OP_XOR   = 4'd6;
    localparam logic [OPW_DEFAULT-1:0] OP_NOT   = 4'd7;
    localparam logic [OPW_DEFAULT-1:0] OP_SHL   = 4'd8;
    localparam logic [OPW_DEFAULT-1:0] OP_SHR   = 4'd9;
    localparam logic [OPW_DEFAULT-1:0] OP_JMP   = 4'd10;
    localparam logic [OPW_DEFAULT-1:0] OP_JZ    = 4'd11;
    localparam logic [OPW_DEFAULT-1:0] OP_CALL  = 4'd12;
    localparam logic [OPW_DEFAULT-1:0] OP_RET   = 4'd13;

    // No multi-cycle ops by default; opcodes 14 and 15 have no control bit.
    localparam logic [(1 << OPW_DEFAULT)-1:0] MULTI_MASK_DEFAULT   = 16'h0000;
    localparam logic [(1 << OPW_DEFAULT)-1:0] ILLEGAL_MASK_DEFAULT = 16'hC000;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MULTI = 1'b1
    } dec_state_t;

endpackage

// File: rtl/instruction_decoder_seq_if.sv
// Bus between instruction fetch (master) and the decoder (slave).
// Handshake: an opcode transfers on a rising edge where op_valid and op_ready
// are both 1; op_ready never depends on op_valid, and OpCode is ignored
// whenever op_ready is 0. Outputs are registered and valid when ctrl_valid=1.
interface instruction_decoder_seq_if
    import instr_dec_pkg::*;
#(
    parameter int OPW          = OPW_DEFAULT,
    parameter int MULTI_CYCLES = 3
);
    localparam int NW = 1 << OPW;
    localparam int SW = $clog2(MULTI_CYCLES);

    logic           op_valid;
    logic           op_ready;
    logic [OPW-1:0] OpCode;
    logic [NW-1:0]  F;
    logic           ctrl_valid;
    logic [SW-1:0]  step;
    logic           last;
    logic           illegal;
    dec_state_t     state;   // decoder FSM state, for observation only

    modport master (
        output op_valid, OpCode,
        input  op_ready, F, ctrl_valid, step, last, illegal, state
    );

    modport slave (
        input  op_valid, OpCode,
        output op_ready, F, ctrl_valid, step, last, illegal, state
    );

endinterface

// File: rtl/instruction_decoder_seq_onehot_decode.sv
// Combinational binary-to-one-hot decoder: output bit `code` is the only bit set.
module onehot_decode #(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0]        code,
    output logic [(1<<OPW)-1:0]   onehot
);

    // Set exactly the bit addressed by the opcode.
    always_comb begin
        onehot       = '0;
        onehot[code] = 1'b1;
    end

endmodule

// File: rtl/instruction_decoder_seq.sv
// Registered instruction decoder. An accepted opcode produces its one-hot
// control word on the following cycle. Multi-cycle opcodes hold the word for
// MULTI_CYCLES cycles with a step index; illegal opcodes pulse `illegal`.
module instruction_decoder_seq
    import instr_dec_pkg::*;
#(
    parameter int                 OPW          = OPW_DEFAULT,
    parameter int                 MULTI_CYCLES = 3,
    parameter logic [2**OPW-1:0]  MULTI_MASK   = MULTI_MASK_DEFAULT,
    parameter logic [2**OPW-1:0]  ILLEGAL_MASK = ILLEGAL_MASK_DEFAULT
) (
    input  logic                             clk,
    input  logic                             reset,
    instruction_decoder_seq_if.slave         bus
);

    localparam int NW = 1 << OPW;
    localparam int SW = $clog2(MULTI_CYCLES);
    localparam logic [SW-1:0] LAST_STEP = SW'(MULTI_CYCLES - 1);

    dec_state_t    state;
    logic [NW-1:0] f_q;
    logic          ctrl_valid_q;
    logic [SW-1:0] step_q;
    logic          last_q;
    logic          illegal_q;

    logic [NW-1:0] dec_onehot;
    logic          ready;
    logic          accept;
    logic          is_illegal;
    logic          is_multi;
    logic [SW-1:0] next_step;

    onehot_decode #(.OPW(OPW)) u_onehot_decode (
        .code   (bus.OpCode),
        .onehot (dec_onehot)
    );

    // Ready in IDLE and in the final hold cycle, so multi-cycle ops chain
    // without a bubble; never ready while reset is held.
    always_comb begin
        ready      = !reset && ((state == ST_IDLE) || (step_q == LAST_STEP));
        accept     = bus.op_valid && ready;
        is_illegal = |(dec_onehot & ILLEGAL_MASK);
        is_multi   = |(dec_onehot & MULTI_MASK) && !is_illegal;
        next_step  = step_q + 1'b1;
    end

    // Decoder FSM with all outputs registered; an accept always wins over
    // finishing the current hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            f_q          <= '0;
            ctrl_valid_q <= 1'b0;
            step_q       <= '0;
            last_q       <= 1'b0;
            illegal_q    <= 1'b0;
        end else if (accept) begin
            step_q    <= '0;
            illegal_q <= is_illegal;
            if (is_illegal) begin
                state        <= ST_IDLE;
                f_q          <= '0;
                ctrl_valid_q <= 1'b0;
                last_q       <= 1'b0;
            end else begin
                state        <= is_multi ? ST_MULTI : ST_IDLE;
                f_q          <= dec_onehot;
                ctrl_valid_q <= 1'b1;
                last_q       <= !is_multi;
            end
        end else if ((state == ST_MULTI) && (step_q != LAST_STEP)) begin
            step_q    <= next_step;
            last_q    <= (next_step == LAST_STEP);
            illegal_q <= 1'b0;
        end else begin
            state        <= ST_IDLE;
            f_q          <= '0;
            ctrl_valid_q <= 1'b0;
            step_q       <= '0;
            last_q       <= 1'b0;
            illegal_q    <= 1'b0;
        end
    end

    // Drive the bus from the registered outputs.
    always_comb begin
        bus.op_ready   = ready;
        bus.F          = f_q;
        bus.ctrl_valid = ctrl_valid_q;
        bus.step       = step_q;
        bus.last       = last_q;
        bus.illegal    = illegal_q;
        bus.state      = state;
    end

endmodule

// File: tb/tb_instruction_decoder_seq.sv
// Bench for instruction_decoder_seq: a 4-bit decoder with opcode 4 multi-cycle
// (3 cycles) under directed and random traffic, plus a 3-bit, 2-cycle variant.
module tb_instruction_decoder_seq;
    import instr_dec_pkg::*;

    localparam logic [15:0] MUL_A = 16'h0010;
    localparam logic [15:0] ILL_A = 16'hC000;
    localparam int          MC_A  = 3;

    typedef struct packed {
        logic [15:0] f;
        logic        cv;
        logic [1:0]  step;
        logic        last;
        logic        ill;
        logic        mul;
    } frame_t;

    logic clk;
    logic a_rst;
    logic b_rst;

    int n_checks = 0;
    int n_errors = 0;
    int n_acc    = 0;
    int dut_insts = 0;

    frame_t exp_q[$];
    frame_t future_q[$];
    logic   rdy_q[$];

    instruction_decoder_seq_if #(.OPW(4), .MULTI_CYCLES(3)) bus_a ();
    instruction_decoder_seq_if #(.OPW(3), .MULTI_CYCLES(2)) bus_b ();

    instruction_decoder_seq #(
        .OPW(4), .MULTI_CYCLES(3), .MULTI_MASK(MUL_A), .ILLEGAL_MASK(ILL_A)
    ) dut_a (
        .clk   (clk),
        .reset (a_rst),
        .bus   (bus_a)
    );

    instruction_decoder_seq #(
        .OPW(3), .MULTI_CYCLES(2), .MULTI_MASK(8'h80), .ILLEGAL_MASK(8'h00)
    ) dut_b (
        .clk   (clk),
        .reset (b_rst),
        .bus   (bus_b)
    );

    // Clock starts high so the first falling edge precedes the first rising edge.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference behaviour at one rising edge: pending hold cycles come first,
    // otherwise an accepted opcode expands into its list of output cycles.
    task automatic model_edge();
        frame_t nxt;
        frame_t fr;
        int     op;
        nxt = '0;
        op  = int'(bus_a.OpCode);
        if (a_rst) begin
            future_q.delete();
        end else if (future_q.size() > 0) begin
            nxt = future_q.pop_front();
        end else if (bus_a.op_valid) begin
            n_acc++;
            if (ILL_A[op]) begin
                nxt.ill = 1'b1;
            end else if (MUL_A[op]) begin
                for (int s = 0; s < MC_A; s++) begin
                    fr      = '0;
                    fr.f    = 16'(1) << op;
                    fr.cv   = 1'b1;
                    fr.step = 2'(s);
                    fr.last = (s == MC_A - 1);
                    fr.mul  = 1'b1;
                    if (s == 0) nxt = fr;
                    else future_q.push_back(fr);
                end
            end else begin
                nxt.f    = 16'(1) << op;
                nxt.cv   = 1'b1;
                nxt.last = 1'b1;
            end
        end
        exp_q.push_back(nxt);
    endtask

    // One cycle of main-DUT stimulus.
    task automatic drive(input logic rst, input logic v, input logic [3:0] op);
        a_rst          = rst;
        bus_a.op_valid = v;
        bus_a.OpCode   = op;
        rdy_q.push_back(!rst && (future_q.size() == 0));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Offer `op` until it is taken; while the decoder is busy the opcode
    // lines carry random values that must be ignored.
    task automatic send(input int op);
        while (future_q.size() != 0) drive(1'b0, 1'b1, 4'($urandom_range(0, 15)));
        drive(1'b0, 1'b1, 4'(op));
    endtask

    // Compare the main DUT against the reference every falling edge.
    always @(negedge clk) begin
        frame_t e;
        frame_t act;
        logic   r;
        if (rdy_q.size() > 0) begin
            r = rdy_q.pop_front();
            check("op_ready", 64'(bus_a.op_ready), 64'(r));
        end
        if (exp_q.size() > 0) begin
            e        = exp_q.pop_front();
            act.f    = bus_a.F;
            act.cv   = bus_a.ctrl_valid;
            act.step = bus_a.step;
            act.last = bus_a.last;
            act.ill  = bus_a.illegal;
            act.mul  = (bus_a.state == ST_MULTI);
            check("frame{F,cv,step,last,ill,multi}", 64'(act), 64'(e));
            if ((act.cv && act.step == 2'd0) || act.ill) dut_insts++;
        end
    end

    initial begin
        a_rst = 1'b1;
        b_rst = 1'b1;
        bus_a.op_valid = 1'b0;
        bus_a.OpCode   = '0;
        bus_b.op_valid = 1'b0;
        bus_b.OpCode   = '0;

        repeat (3) drive(1'b1, 1'b0, 4'd0);

        // Every defined opcode back-to-back.
        for (int n = 0; n < 14; n++) send(n);
        // Illegal opcodes, then a legal one.
        send(14);
        send(15);
        send(5);
        // Multi-cycle op chained straight into a single-cycle op.
        send(4);
        send(2);
        repeat (2) drive(1'b0, 1'b0, 4'd0);
        // Reset arriving on step 1 of a multi-cycle op.
        send(4);
        drive(1'b0, 1'b0, 4'd0);
        drive(1'b1, 1'b1, 4'd6);
        send(3);
        repeat (2) drive(1'b0, 1'b0, 4'd0);
        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 15)));
        end
        repeat (4) drive(1'b0, 1'b0, 4'd0);

        // Narrow variant: OPW=3, two-cycle hold on opcode 7, nothing illegal.
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("b reset op_ready", 64'(bus_b.op_ready), 64'd0);
        check("b reset ctrl_valid", 64'(bus_b.ctrl_valid), 64'd0);
        b_rst = 1'b0;
        #1;
        check("b op_ready after reset", 64'(bus_b.op_ready), 64'd1);
        bus_b.op_valid = 1'b1;
        bus_b.OpCode   = 3'd7;
        @(posedge clk); #1;
        bus_b.OpCode   = 3'd1;
        check("b F step0", 64'(bus_b.F), 64'h80);
        check("b ctrl_valid step0", 64'(bus_b.ctrl_valid), 64'd1);
        check("b step0", 64'(bus_b.step), 64'd0);
        check("b last step0", 64'(bus_b.last), 64'd0);
        check("b op_ready step0", 64'(bus_b.op_ready), 64'd0);
        @(posedge clk); #1;
        bus_b.op_valid = 1'b0;
        check("b F step1", 64'(bus_b.F), 64'h80);
        check("b step1", 64'(bus_b.step), 64'd1);
        check("b last step1", 64'(bus_b.last), 64'd1);
        check("b op_ready step1", 64'(bus_b.op_ready), 64'd1);
        @(posedge clk); #1;
        check("b F idle", 64'(bus_b.F), 64'h00);
        check("b ctrl_valid idle", 64'(bus_b.ctrl_valid), 64'd0);
        bus_b.op_valid = 1'b1;
        bus_b.OpCode   = 3'd3;
        @(posedge clk); #1;
        bus_b.op_valid = 1'b0;
        check("b F op3", 64'(bus_b.F), 64'h08);
        check("b last op3", 64'(bus_b.last), 64'd1);
        check("b illegal op3", 64'(bus_b.illegal), 64'd0);
        @(negedge clk); #1;

        check("a instruction count", 64'(dut_insts), 64'(n_acc));
        check("a pending expectations", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instruction_decoder_seq.md
# instruction_decoder_seq

Registered, parametrised successor to the gate-level instruction decoder. Accepts an OPW-bit opcode over a valid/ready handshake and emits a one-hot control word, one cycle after acceptance. Opcodes flagged as multi-cycle hold their control word for MULTI_CYCLES consecutive cycles with a step index; opcodes flagged illegal raise an error pulse instead. Sits between instruction fetch and the datapath control inputs.

## Interface
- OPW, 4: opcode width; control word width is 2**OPW.
- MULTI_CYCLES, 3: cycles a multi-cycle opcode is held; legal range 2..16.
- MULTI_MASK, 16'h0000: bit i set means opcode i is multi-cycle; width 2**OPW.
- ILLEGAL_MASK, 16'hC000: bit i set means opcode i is illegal (default: opcodes 14 and 15, matching the 14 defined controls); width 2**OPW. ILLEGAL_MASK takes precedence over MULTI_MASK.
- clk, input, 1: sole clock, rising edge.
- reset, input, 1: synchronous, active-high.
- op_valid, input, 1: opcode offered.
- op_ready, output, 1: decoder can accept this cycle.
- OpCode, input, OPW: opcode, sampled on accept.
- F, output, 2**OPW: registered one-hot control word; all-zero when ctrl_valid=0.
- ctrl_valid, output, 1: F is valid this cycle.
- step, output, $clog2(MULTI_CYCLES): step index of current control word; 0 for single-cycle ops.
- last, output, 1: final cycle of the current instruction (always 1 with ctrl_valid for single-cycle ops).
- illegal, output, 1: one-cycle pulse; the accepted opcode was illegal.

## Operation
- Accept = op_valid && op_ready at a rising edge.
- States: IDLE, MULTI.
- IDLE: op_ready=1. On accept of opcode n:
  - illegal n: next cycle illegal=1, ctrl_valid=0, F=0; stay IDLE.
  - single-cycle n: next cycle F=1<<n, ctrl_valid=1, step=0, last=1; stay IDLE.
  - multi-cycle n: next cycle F=1<<n, ctrl_valid=1, step=0, last=0; go to MULTI.
  - No accept: ctrl_valid=0, F=0, illegal=0.
- MULTI: F held, step increments by 1 each cycle; last=1 when step==MULTI_CYCLES-1. op_ready=1 only in the last cycle (step==MULTI_CYCLES-1). Accept in that cycle is processed exactly as an accept in IDLE (no bubble). Without an accept, the state returns to IDLE and the outputs clear the next cycle.
- OpCode is sampled only on accept; changes while op_ready=0 are ignored.
- Multi-cycle and single-cycle classification is taken from the accepted opcode, not from the live input.

## Timing
- Latency: accept at edge k -> F valid from edge k+1 (one register stage, no combinational path from OpCode to F).
- Throughput: 1 instruction/cycle for single-cycle ops. MULTI_CYCLES cycles per multi-cycle op, back-to-back with no gap.
- op_ready is combinational from state, step and reset only. It must not depend on op_valid.
- Reset (synchronous, any state, including mid-MULTI): at the next edge F=0, ctrl_valid=0, step=0, last=0, illegal=0, state=IDLE. op_ready=0 while reset is high, and 1 in the first cycle after deassertion. An instruction in flight is discarded, not completed.
- An opcode offered on the same cycle reset is high is not accepted.

## Structure
- Shared package instr_dec_pkg holds:
  - default OPW;
  - the opcode localparams for the 14 defined operations;
  - the default MULTI_MASK and ILLEGAL_MASK;
  - the state encoding (IDLE=1'b0, MULTI=1'b1).
- One sub-module, onehot_decode (OPW in, 2**OPW one-hot out, purely combinational). It generalises the existing gate-level decoder and feeds the F register.

## Test plan
- Reset, then OpCode 0..13 back-to-back with op_valid=1 (defaults) -> F=1<<n one cycle after each accept, ctrl_valid=1 on 14 consecutive cycles, last=1, step=0, op_ready constantly 1.
- OpCode 14, then 15 -> illegal=1 for one cycle each, F=0, ctrl_valid=0; next legal opcode decodes normally.
- MULTI_MASK=16'h0010, MULTI_CYCLES=3, OpCode 4 followed immediately by OpCode 2:
  - F=16'h0010 for 3 cycles, step=0,1,2, last only on step 2;
  - op_ready=0 for the first 2 output cycles;
  - F=16'h0004 on the very next cycle.
- During that MULTI hold, OpCode toggles with op_valid=1 -> F unchanged, no extra accepts; the accept count matches the output instruction count.
- Reset asserted at step 1 of a multi-cycle op -> next cycle all outputs 0 and state IDLE. After deassertion, OpCode 3 decodes to F=16'h0008 one cycle after accept.
- OPW=3, MULTI_CYCLES=2, all opcodes legal, OpCode 7 -> F=8'h80, step width 1, last on step 1.
